// File: rtl/msdap_out_scheduler.sv
// rtl/msdap_out_scheduler.sv - MSDAP stereo output scheduler: L/R pairing, pair FIFO, one serializer launch per frame slot
// Optional macro MSDAP_ZERO_FILL_EN: an empty-FIFO slot launches an all-zero pair instead of being skipped.
module msdap_out_scheduler #(
    parameter int DEPTH = 4,
    parameter int DW    = 40
) (
    input  logic                    SCLK,
    input  logic                    CLR,
    input  logic                    EN,
    input  logic                    FRAME,
    input  logic [DW-1:0]           RES_L,
    input  logic                    RES_L_VALID,
    output logic                    RES_L_READY,
    input  logic [DW-1:0]           RES_R,
    input  logic                    RES_R_VALID,
    output logic                    RES_R_READY,
    output logic [DW-1:0]           P2S_DATA_L,
    output logic [DW-1:0]           P2S_DATA_R,
    output logic                    P2S_FRAME,
    output logic                    P2S_EN,
    input  logic                    P2S_BUSY,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic                    UNDERRUN,
    output logic                    SLOT_MISS
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARM, WAIT_BUSY, SHIFT} state_t;

    state_t          state_q;
    logic [DW-1:0]   hold_l_q, hold_r_q;
    logic            hold_l_full_q, hold_r_full_q;
    logic [2*DW-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q;
    logic            frame_q, p2s_frame_q, underrun_q, slot_miss_q, zero_q;
    logic [DW-1:0]   p2s_l_q, p2s_r_q;
    logic            slot_open, take_l, take_r, push, pop;

    assign slot_open = EN & FRAME & ~frame_q;
    assign take_l    = RES_L_VALID & ~hold_l_full_q;
    assign take_r    = RES_R_VALID & ~hold_r_full_q;
    assign push      = hold_l_full_q & hold_r_full_q & (level_q != FULL_LEVEL);
    // A zero-fill launch has no FIFO entry behind it, so it must not pop.
    assign pop       = (state_q == WAIT_BUSY) & P2S_BUSY & ~zero_q;

    always_ff @(posedge SCLK) begin
        if (!CLR && EN && push) begin
            mem_q[wr_ptr_q] <= {hold_l_q, hold_r_q};
        end
    end

    always_ff @(posedge SCLK) begin
        if (CLR) begin
            state_q       <= IDLE;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            hold_l_full_q <= 1'b0;
            hold_r_full_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            frame_q       <= 1'b0;
            p2s_frame_q   <= 1'b0;
            p2s_l_q       <= '0;
            p2s_r_q       <= '0;
            underrun_q    <= 1'b0;
            slot_miss_q   <= 1'b0;
            zero_q        <= 1'b0;
        end else if (EN) begin
            frame_q <= FRAME;

            if (push) begin
                hold_l_full_q <= 1'b0;
                hold_r_full_q <= 1'b0;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
            if (take_l) begin
                hold_l_q      <= RES_L;
                hold_l_full_q <= 1'b1;
            end
            if (take_r) begin
                hold_r_q      <= RES_R;
                hold_r_full_q <= 1'b1;
            end

            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase

            if (slot_open && state_q != IDLE) slot_miss_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (slot_open) begin
                        if (level_q == '0) underrun_q <= 1'b1;
                        if (P2S_BUSY) begin
                            slot_miss_q <= 1'b1;
                        end else if (level_q != '0) begin
                            {p2s_l_q, p2s_r_q} <= mem_q[rd_ptr_q];
                            zero_q             <= 1'b0;
                            state_q            <= ARM;
                        end
`ifdef MSDAP_ZERO_FILL_EN
                        else begin
                            p2s_l_q <= '0;
                            p2s_r_q <= '0;
                            zero_q  <= 1'b1;
                            state_q <= ARM;
                        end
`endif
                    end
                end
                ARM: begin
                    p2s_frame_q <= 1'b1;
                    state_q     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    p2s_frame_q <= 1'b0;
                    if (P2S_BUSY) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (!P2S_BUSY) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign RES_L_READY = ~hold_l_full_q;
    assign RES_R_READY = ~hold_r_full_q;
    assign P2S_DATA_L  = p2s_l_q;
    assign P2S_DATA_R  = p2s_r_q;
    assign P2S_FRAME   = p2s_frame_q;
    assign P2S_EN      = EN;
    assign LEVEL       = level_q;
    assign UNDERRUN    = underrun_q;
    assign SLOT_MISS   = slot_miss_q;
endmodule
